// File: rtl/tetris_pkg.sv
// Shared types for the Tetris input controller.
// Button indices, repeat FSM states and channel count.
package tetris_pkg;

  localparam int NUM_BTNS = 4;

  typedef enum logic [1:0] {
    BTN_DOWN  = 2'd0,
    BTN_LEFT  = 2'd1,
    BTN_RIGHT = 2'd2,
    BTN_ROT   = 2'd3
  } btn_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    DAS,
    REPEAT
  } rep_state_t;

  typedef enum logic {
    RELEASED,
    HELD
  } hold_state_t;

endpackage

// File: rtl/tetris_btn_channel.sv
// One button: 2-FF sync, debounce, press edge, optional auto-repeat.
// REPEAT_EN=0 reduces the FSM to RELEASED/HELD with no timer.
module tetris_btn_channel
  import tetris_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int DAS_CYCLES      = 10,
  parameter int ARR_CYCLES      = 3,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press,
  output logic move
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 ||
      DAS_CYCLES < 1 || DAS_CYCLES > 255 ||
      ARR_CYCLES < 1 || ARR_CYCLES > 255) begin : g_bad_param
    $error("tetris_btn_channel: cycle parameter out of 1..255");
  end

  logic       s1;
  logic       s2;
  logic [7:0] cnt;
  logic       flip;
  logic       rise;
  logic       fall;
  logic       move_d;

  // Two-flop synchronizer for the raw asynchronous button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  assign flip = (s2 != level) &&
                (cnt == 8'(DEBOUNCE_CYCLES - 1));
  assign rise = flip & ~level;
  assign fall = flip & level;

  // Debounce: flip level after N consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (s2 == level) begin
      cnt <= '0;
    end else if (flip) begin
      cnt   <= '0;
      level <= ~level;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  if (REPEAT_EN) begin : g_rep
    rep_state_t state_q;
    rep_state_t state_d;
    logic [7:0] tmr_q;
    logic [7:0] tmr_d;

    // Repeat FSM state and timer registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        tmr_q   <= '0;
      end else begin
        state_q <= state_d;
        tmr_q   <= tmr_d;
      end
    end

    // Press pulse, then DAS delay, then fixed-rate repeats
    always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      move_d  = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            move_d  = 1'b1;
            tmr_d   = 8'(DAS_CYCLES);
            state_d = DAS;
          end
        end
        DAS, REPEAT: begin
          if (fall) begin
            state_d = IDLE;
          end else if (tmr_q == 8'd1) begin
            move_d  = 1'b1;
            tmr_d   = 8'(ARR_CYCLES);
            state_d = REPEAT;
          end else begin
            tmr_d = tmr_q - 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end else begin : g_hold
    hold_state_t state_q;
    hold_state_t state_d;

    // Held/released tracking register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= RELEASED;
      else        state_q <= state_d;
    end

    // Single pulse on press, nothing while held
    always_comb begin
      state_d = state_q;
      move_d  = 1'b0;
      unique case (state_q)
        RELEASED: begin
          if (rise) begin
            move_d  = 1'b1;
            state_d = HELD;
          end
        end
        HELD: begin
          if (fall) state_d = RELEASED;
        end
        default: state_d = RELEASED;
      endcase
    end
  end

  // Registered press-edge and move pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press <= 1'b0;
      move  <= 1'b0;
    end else begin
      press <= rise;
      move  <= move_d;
    end
  end

endmodule

// File: rtl/tetris_input_ctrl.sv
// Tetris button front end: four channels, L/R conflict mask, enable gate.
// Auto-repeat on down/left/right only when INPUT_REPEAT_EN is defined.
module tetris_input_ctrl
  import tetris_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int DAS_CYCLES      = 10,
  parameter int ARR_CYCLES      = 3
) (
  input  logic gm_clk,
  input  logic gm_rst_n,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_rot,
  input  logic game_en,
  output logic down,
  output logic left,
  output logic right,
  output logic rott,
  output logic any_press
);

`ifdef INPUT_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic [NUM_BTNS-1:0] raw;
  logic [NUM_BTNS-1:0] level;
  logic [NUM_BTNS-1:0] press;
  logic [NUM_BTNS-1:0] move;
  logic                lr_both;
  logic                unused_level;

  assign raw[BTN_DOWN]  = btn_down;
  assign raw[BTN_LEFT]  = btn_left;
  assign raw[BTN_RIGHT] = btn_right;
  assign raw[BTN_ROT]   = btn_rot;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    tetris_btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DAS_CYCLES     (DAS_CYCLES),
      .ARR_CYCLES     (ARR_CYCLES),
      .REPEAT_EN      ((i == int'(BTN_ROT)) ? 1'b0 : REP)
    ) u_ch (
      .clk  (gm_clk),
      .rst_n(gm_rst_n),
      .raw  (raw[i]),
      .level(level[i]),
      .press(press[i]),
      .move (move[i])
    );
  end

  assign lr_both      = level[BTN_LEFT] & level[BTN_RIGHT];
  assign unused_level = level[BTN_DOWN] ^ level[BTN_ROT];

  assign down      = game_en & move[BTN_DOWN];
  assign left      = game_en & move[BTN_LEFT] & ~lr_both;
  assign right     = game_en & move[BTN_RIGHT] & ~lr_both;
  assign rott      = game_en & move[BTN_ROT];
  assign any_press = |press;

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Bench for tetris_input_ctrl: directed table, reset sequence, random run.
// Reference model follows INPUT_REPEAT_EN like the design.
module tb_tetris_input_ctrl;

  localparam int DB  = 3;
  localparam int DAS = 10;
  localparam int ARR = 3;
`ifdef INPUT_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  typedef struct {
    logic [3:0] btn;
    logic       en;
    int         n;
    int         e_down;
    int         e_left;
    int         e_right;
    int         e_rot;
    int         e_any;
  } row_t;

  logic       gm_clk = 1'b0;
  logic       gm_rst_n = 1'b0;
  logic [3:0] btn = 4'b0;
  logic       game_en = 1'b1;
  logic       down, left, right, rott, any_press;

  int checks = 0;
  int errors = 0;
  int cnt[5];

  bit [15:0] hist[4];
  bit        mdb[4];
  bit        mrise[4];
  bit        mmv[4];
  int        pt[4];
  int        t;

  row_t rows[$];

  tetris_input_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .DAS_CYCLES     (DAS),
    .ARR_CYCLES     (ARR)
  ) dut (
    .gm_clk   (gm_clk),
    .gm_rst_n (gm_rst_n),
    .btn_down (btn[0]),
    .btn_left (btn[1]),
    .btn_right(btn[2]),
    .btn_rot  (btn[3]),
    .game_en  (game_en),
    .down     (down),
    .left     (left),
    .right    (right),
    .rott     (rott),
    .any_press(any_press)
  );

  always #5 gm_clk = ~gm_clk;

  task automatic model_reset();
    t = 0;
    for (int b = 0; b < 4; b++) begin
      hist[b]  = '0;
      mdb[b]   = 1'b0;
      mrise[b] = 1'b0;
      mmv[b]   = 1'b0;
      pt[b]    = 0;
    end
  endtask

  // hist[b][k] = raw sampled k+1 edges ago; the synced level seen at
  // an edge is raw from two edges earlier, so the last DB synced
  // samples are hist bits 1..DB.
  task automatic model_step();
    t++;
    for (int b = 0; b < 4; b++) begin
      bit flip;
      int age;
      flip = 1'b1;
      for (int k = 1; k <= DB; k++)
        if (hist[b][k] == mdb[b]) flip = 1'b0;
      hist[b]  = {hist[b][14:0], btn[b]};
      mrise[b] = flip && !mdb[b];
      if (flip) mdb[b] = !mdb[b];
      if (mrise[b]) pt[b] = t;
      age = t - pt[b];
      mmv[b] = mdb[b] && (mrise[b] ||
               (REP && b != 3 && age >= DAS &&
                ((age - DAS) % ARR) == 0));
    end
  endtask

  function automatic logic [4:0] model_out();
    bit c;
    c = mdb[1] && mdb[2];
    return {mmv[0] && game_en,
            mmv[1] && game_en && !c,
            mmv[2] && game_en && !c,
            mmv[3] && game_en,
            mrise[0] || mrise[1] || mrise[2] || mrise[3]};
  endfunction

  task automatic check_now();
    logic [4:0] got;
    logic [4:0] exp;
    got = {down, left, right, rott, any_press};
    exp = model_out();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL model t=%0d {dn,l,r,rot,any} got %b expected %b",
               t, got, exp);
    end
    for (int i = 0; i < 5; i++)
      if (got[4-i] === 1'b1) cnt[i]++;
  endtask

  task automatic cycle();
    @(posedge gm_clk);
    if (gm_rst_n) model_step();
    else          model_reset();
    @(negedge gm_clk);
    check_now();
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic add_row(input logic [3:0] b, input logic en,
                         input int n, input int ed, input int el,
                         input int er, input int eo, input int ea);
    row_t r;
    r.btn = b; r.en = en; r.n = n;
    r.e_down = ed; r.e_left = el; r.e_right = er;
    r.e_rot = eo; r.e_any = ea;
    rows.push_back(r);
  endtask

  initial begin
    int first;

    // btn bits: [0]=down [1]=left [2]=right [3]=rot
    add_row(4'b0000, 1, 8,  0, 0, 0, 0, 0);
    add_row(4'b0010, 1, 5,  0, 1, 0, 0, 1);
    add_row(4'b0000, 1, 10, 0, 0, 0, 0, 0);
    add_row(4'b1000, 1, 1,  0, 0, 0, 0, 0);
    add_row(4'b0000, 1, 1,  0, 0, 0, 0, 0);
    add_row(4'b1000, 1, 1,  0, 0, 0, 0, 0);
    add_row(4'b1000, 1, 10, 0, 0, 0, 1, 1);
    add_row(4'b0000, 1, 10, 0, 0, 0, 0, 0);
    add_row(4'b0001, 1, 30, REP ? 7 : 1, 0, 0, 0, 1);
    add_row(4'b0000, 1, 10, REP ? 1 : 0, 0, 0, 0, 0);
    add_row(4'b0010, 1, 20, 0, REP ? 3 : 1, 0, 0, 1);
    add_row(4'b0110, 1, 12, 0, REP ? 2 : 0, 0, 0, 1);
    add_row(4'b0010, 1, 12, 0, REP ? 2 : 0, 0, 0, 0);
    add_row(4'b0000, 1, 10, 0, REP ? 2 : 0, 0, 0, 0);
    add_row(4'b0100, 0, 8,  0, 0, 0, 0, 1);
    add_row(4'b0000, 0, 10, 0, 0, 0, 0, 0);
    add_row(4'b0000, 1, 5,  0, 0, 0, 0, 0);

    model_reset();
    #1;
    chk("reset_outputs", int'({down, left, right, rott, any_press}), 0);
    repeat (3) cycle();
    gm_rst_n = 1'b1;

    foreach (rows[i]) begin
      btn     = rows[i].btn;
      game_en = rows[i].en;
      for (int k = 0; k < 5; k++) cnt[k] = 0;
      repeat (rows[i].n) cycle();
      chk($sformatf("row%0d_down", i),  cnt[0], rows[i].e_down);
      chk($sformatf("row%0d_left", i),  cnt[1], rows[i].e_left);
      chk($sformatf("row%0d_right", i), cnt[2], rows[i].e_right);
      chk($sformatf("row%0d_rot", i),   cnt[3], rows[i].e_rot);
      chk($sformatf("row%0d_any", i),   cnt[4], rows[i].e_any);
    end

    // Reset while down is auto-repeating, button held through release
    btn = 4'b0001;
    repeat (18) cycle();
    chk("pre_reset_down", int'(down), int'(REP));
    gm_rst_n = 1'b0;
    model_reset();
    #1;
    chk("reset_mid_repeat", int'({down, left, right, rott, any_press}), 0);
    repeat (3) cycle();
    gm_rst_n = 1'b1;
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      if (down && first == 0) first = k;
    end
    chk("press_after_reset_edge", first, DB + 2);
    btn = 4'b0000;
    repeat (12) cycle();

    // Random buttons and enable against the model
    for (int c = 0; c < 800; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(11) == 0) btn[b] = ~btn[b];
      if ($urandom_range(39) == 0) game_en = ~game_en;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
